// File: rtl/cpu_pkg.sv
// Shared CPU definitions: redirect kinds, widths, reset vector and the
// redirect-target computation used by fetch, decode and the reference model.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'b00,
    REDIR_BRANCH = 2'b01,
    REDIR_JUMP   = 2'b10,
    REDIR_JR     = 2'b11
  } redir_kind_e;

  // Target of a redirecting instruction; all arithmetic wraps mod 2^32.
  // REDIR_NONE falls through to pc+4 so callers never see an X target.
  function automatic logic [31:0] redirect_target(
    input logic [1:0]  kind,
    input logic [31:0] pc,
    input logic [15:0] imm16,
    input logic [25:0] target26,
    input logic [31:0] rs
  );
    logic [31:0] p4;
    logic [31:0] result;
    p4 = pc + 32'd4;
    case (kind)
      REDIR_BRANCH: result = p4 + {{14{imm16[15]}}, imm16, 2'b00};
      REDIR_JUMP:   result = {p4[31:28], target26, 2'b00};
      REDIR_JR:     result = {rs[31:2], 2'b00};
      default:      result = p4;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two circular FIFO with synchronous flush.
// Push and pop may happen in the same cycle, including when full.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop only a live entry; a push into a full buffer is legal only alongside a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the buffer in one cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage: owns the PC, issues requests to a
// 1-cycle-latency instruction memory, buffers responses and hands them to
// decode over valid/ready. Downstream redirects flush wrong-path work.
//
// Handshake: an entry moves to decode in a cycle where id_valid and id_ready
// are both high; id_inst/id_pc/id_pc_plus4 are stable while id_valid is high
// and id_ready is low, and are meaningless while id_valid is low.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [1:0]  redir_kind,
  input  logic [31:0] redir_pc,
  input  logic [15:0] redir_imm16,
  input  logic [25:0] redir_target26,
  input  logic [31:0] redir_reg,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]     pc;
  logic [31:0]     req_addr;   // address of the request currently in flight
  logic            inflight;
  logic            squash;
  logic            redir;
  logic [31:0]     target;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occupancy;
  logic [CW-1:0]   count;
  logic [63:0]     head;

  assign redir  = redir_valid && (redir_kind != REDIR_NONE);
  assign target = redirect_target(redir_kind, redir_pc, redir_imm16,
                                  redir_target26, redir_reg);

  // Entries already buffered plus the one still in memory, minus the one
  // leaving this cycle, must leave room for the response to a new request.
  assign occupancy = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign issue     = !reset && !redir && (occupancy < (CW + 1)'(DEPTH));

  // A response is dropped if a redirect is in progress now or was last cycle.
  assign push = inflight && !squash && !redir;
  assign pop  = id_valid && id_ready;

  assign imem_en     = issue;
  assign imem_addr   = pc;
  assign id_valid    = (count != '0) && !reset;
  assign id_inst     = head[63:32];
  assign id_pc       = head[31:0];
  assign id_pc_plus4 = head[31:0] + 32'd4;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redir),
    .push      (push),
    .push_data ({imem_rdata, req_addr}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // PC sequencing, in-flight tracking and redirect squash; reset beats redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      inflight <= 1'b0;
      squash   <= 1'b0;
    end else begin
      squash   <= redir;
      inflight <= issue;
      if (issue) begin
        req_addr <= pc;
      end
      if (redir) begin
        pc <= target;
      end else if (issue) begin
        pc <= pc + 32'd4;
      end
    end
  end

endmodule
